// File: rtl/n64adv_sync_pkg.sv
// Shared constants for the register synchronisers feeding the CPU subsystem.
package n64adv_sync_pkg;

  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  // Attribute carried by every synchroniser flop so tools keep the chain intact.
  function automatic string sync_attr();
    return "synchronizer";
  endfunction

  function automatic int unsigned clamp_min(input int unsigned value, input int unsigned lo);
    return (value < lo) ? lo : value;
  endfunction

endpackage

// File: rtl/cdc_register_sync_if.sv
// Bus-side signals of cdc_register_sync: source bus in, synchronised bus and strobe out.
interface cdc_register_sync_if #(
  parameter int unsigned reg_width = 1
);
  logic                 clk_en;
  logic [reg_width-1:0] reg_i;
  logic [reg_width-1:0] reg_o;
  logic                 changed_o;

  modport master (output clk_en, reg_i, input reg_o, changed_o);
  modport slave  (input clk_en, reg_i, output reg_o, changed_o);
endinterface

// File: rtl/sync_bit_chain.sv
// Single-bit N-stage synchroniser chain with preset value and stage-advance enable.
module sync_bit_chain #(
  parameter int unsigned stages = 2,
  parameter logic        preset = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic d,
  output logic q
);

  (* synchronizer = "true", async_reg = "true" *) logic [stages-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {stages{preset}};
    end else if (clk_en) begin
      chain <= {chain[stages-2:0], d};
    end
  end

  assign q = chain[stages-1];

endmodule

// File: rtl/cdc_register_sync.sv
// Multi-bit register synchroniser with preset, enable and one-cycle change strobe.
// Optional stability filter: define REG_SYNC_STABLE_FILTER_EN.
module cdc_register_sync
  import n64adv_sync_pkg::*;
#(
  parameter int unsigned          reg_width     = 1,
  parameter logic [reg_width-1:0] reg_preset    = '0,
  parameter int unsigned          sync_stages   = DEFAULT_SYNC_STAGES,
  parameter int unsigned          stable_cycles = DEFAULT_STABLE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  cdc_register_sync_if.slave  bus
);

  localparam int unsigned STAGES = clamp_min(sync_stages, 2);

  logic [reg_width-1:0] last;
  logic [reg_width-1:0] reg_q;
  logic                 changed_q;

  for (genvar i = 0; i < int'(reg_width); i++) begin : g_bit
    sync_bit_chain #(
      .stages (STAGES),
      .preset (reg_preset[i])
    ) u_chain (
      .clk    (clk),
      .rst    (rst),
      .clk_en (bus.clk_en),
      .d      (bus.reg_i[i]),
      .q      (last[i])
    );
  end

`ifdef REG_SYNC_STABLE_FILTER_EN
  localparam int unsigned        STABLE  = clamp_min(stable_cycles, 1);
  localparam int unsigned        CNT_W   = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE);

  logic [reg_width-1:0] prev_q;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 update;

  // Update is judged on the count this edge produces, so a value held
  // stable_cycles enabled cycles at the chain end lands on that same edge.
  always_comb begin
    cnt_next = cnt;
    if (last != prev_q) begin
      cnt_next = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
    update = (cnt_next == CNT_MAX) && (last != reg_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= reg_preset;
      cnt       <= '0;
      reg_q     <= reg_preset;
      changed_q <= 1'b0;
    end else if (bus.clk_en) begin
      prev_q    <= last;
      cnt       <= cnt_next;
      changed_q <= update;
      if (update) begin
        reg_q <= last;
      end
    end else begin
      changed_q <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q     <= reg_preset;
      changed_q <= 1'b0;
    end else if (bus.clk_en) begin
      reg_q     <= last;
      changed_q <= (last != reg_q);
    end else begin
      changed_q <= 1'b0;
    end
  end
`endif

  assign bus.reg_o     = reg_q;
  assign bus.changed_o = changed_q;

endmodule

// File: tb/tb_cdc_register_sync.sv
// Directed bench for cdc_register_sync (plain build or REG_SYNC_STABLE_FILTER_EN).
module tb_cdc_register_sync;

`ifdef REG_SYNC_STABLE_FILTER_EN
  localparam int unsigned LAT = 2 + 4 + 1;
`else
  localparam int unsigned LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdc_register_sync_if #(.reg_width(4)) bus4 ();
  cdc_register_sync_if #(.reg_width(8)) bus8 ();

  cdc_register_sync #(
    .reg_width     (4),
    .reg_preset    (4'hA),
    .sync_stages   (2),
    .stable_cycles (4)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  cdc_register_sync #(
    .reg_width     (8),
    .reg_preset    (8'h00),
    .sync_stages   (2),
    .stable_cycles (4)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps dut4 edge by edge after reg_i has changed: old value until the
  // latency edge, new value with a one-cycle strobe on it, then quiet.
  task automatic run_lat4(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
    for (int unsigned k = 1; k <= LAT + 1; k++) begin
      tick(1);
      check_eq({tag, "_reg"}, 64'(bus4.reg_o), 64'((k < LAT) ? old_v : new_v));
      check_eq({tag, "_chg"}, 64'(bus4.changed_o), 64'(k == LAT));
    end
  endtask

  initial begin
    // Reset held with a non-preset input
    rst          = 1'b1;
    bus4.clk_en  = 1'b1;
    bus4.reg_i   = 4'h5;
    bus8.clk_en  = 1'b1;
    bus8.reg_i   = 8'h00;
    #2;
    check_eq("rst_hold_reg4", 64'(bus4.reg_o), 64'hA);
    check_eq("rst_hold_chg4", 64'(bus4.changed_o), 64'h0);
    tick(2);
    check_eq("rst_hold2_reg4", 64'(bus4.reg_o), 64'hA);
    check_eq("rst_hold_reg8", 64'(bus8.reg_o), 64'h00);
    #3 rst = 1'b0;
    tick(1);
    check_eq("rst_rel_reg4", 64'(bus4.reg_o), 64'hA);
    check_eq("rst_rel_chg4", 64'(bus4.changed_o), 64'h0);

    // Latency: settle on 0, then step to 9
    bus4.reg_i = 4'h0;
    tick(LAT + 6);
    check_eq("settle_reg4", 64'(bus4.reg_o), 64'h0);
    check_eq("settle_chg4", 64'(bus4.changed_o), 64'h0);
    bus4.reg_i = 4'h9;
    run_lat4("lat", 4'h0, 4'h9);

    // Enable gating
    bus4.clk_en = 1'b0;
    bus4.reg_i  = 4'h1;
    for (int unsigned k = 0; k < 10; k++) begin
      tick(1);
      check_eq("gate_reg4", 64'(bus4.reg_o), 64'h9);
      check_eq("gate_chg4", 64'(bus4.changed_o), 64'h0);
    end
    bus4.clk_en = 1'b1;
    run_lat4("ungate", 4'h9, 4'h1);

    // Asynchronous reset between the 1st and 2nd edge after a change
    bus4.reg_i = 4'h3;
    tick(1);
    rst = 1'b1;
    #2;
    check_eq("midrst_reg4", 64'(bus4.reg_o), 64'hA);
    check_eq("midrst_chg4", 64'(bus4.changed_o), 64'h0);
    #2 rst = 1'b0;
    run_lat4("midrst", 4'hA, 4'h3);

    // Two-cycle glitch 00 -> 3C -> 00 on the 8-bit instance
    tick(LAT + 6);
    check_eq("pre_glitch_reg8", 64'(bus8.reg_o), 64'h00);
    bus8.reg_i = 8'h3C;
`ifdef REG_SYNC_STABLE_FILTER_EN
    tick(2);
    check_eq("glitch_reg8", 64'(bus8.reg_o), 64'h00);
    bus8.reg_i = 8'h00;
    for (int unsigned k = 0; k < 10; k++) begin
      tick(1);
      check_eq("glitch_reg8", 64'(bus8.reg_o), 64'h00);
      check_eq("glitch_chg8", 64'(bus8.changed_o), 64'h0);
    end
`else
    tick(1);
    check_eq("glitch_e1_reg8", 64'(bus8.reg_o), 64'h00);
    tick(1);
    check_eq("glitch_e2_reg8", 64'(bus8.reg_o), 64'h00);
    bus8.reg_i = 8'h00;
    tick(1);
    check_eq("glitch_e3_reg8", 64'(bus8.reg_o), 64'h3C);
    check_eq("glitch_e3_chg8", 64'(bus8.changed_o), 64'h1);
    tick(1);
    check_eq("glitch_e4_reg8", 64'(bus8.reg_o), 64'h3C);
    check_eq("glitch_e4_chg8", 64'(bus8.changed_o), 64'h0);
    tick(1);
    check_eq("glitch_e5_reg8", 64'(bus8.reg_o), 64'h00);
    check_eq("glitch_e5_chg8", 64'(bus8.changed_o), 64'h1);
    tick(1);
    check_eq("glitch_e6_chg8", 64'(bus8.changed_o), 64'h0);
    tick(4);
`endif

    // Held value crosses after the full latency
    bus8.reg_i = 8'h3C;
    for (int unsigned k = 1; k <= LAT + 1; k++) begin
      tick(1);
      check_eq("hold_reg8", 64'(bus8.reg_o), (k < LAT) ? 64'h00 : 64'h3C);
      check_eq("hold_chg8", 64'(bus8.changed_o), 64'(k == LAT));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
